// File: rtl/tracker_pkg.sv
// Shared types and constants for the voice/envelope datapath.
// Envelope state encoding and default level/midpoint constants.
package tracker_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] ENV_MAX          = 16'hFFFF;
    localparam logic [15:0] MIDPOINT_DEFAULT = 16'h4000;

endpackage

// File: rtl/envelope_scaler.sv
// Two-stage scaler: recentre the sample, multiply by the envelope,
// then shift back down and re-offset about the midpoint.
module envelope_scaler #(
    parameter int                      ENV_WIDTH    = 16,
    parameter int                      SAMPLE_WIDTH = 16,
    parameter logic [SAMPLE_WIDTH-1:0] MIDPOINT     = 16'h4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [ENV_WIDTH-1:0]    env_level,
    output logic [SAMPLE_WIDTH-1:0] sample_out
);

    localparam int CW = SAMPLE_WIDTH + 1;
    localparam int PW = CW + ENV_WIDTH + 1;

    logic signed [CW-1:0]        centered;
    logic signed [ENV_WIDTH:0]   gain;
    logic signed [PW-1:0]        product;
    logic signed [PW-1:0]        product_q;
    logic [SAMPLE_WIDTH-1:0]     rescaled;

    assign centered = $signed({1'b0, sample_in}) - $signed({1'b0, MIDPOINT});
    assign gain     = $signed({1'b0, env_level});
    assign product  = PW'(centered) * PW'(gain);
    // Arithmetic shift floors toward minus infinity, keeping output in range
    assign rescaled = MIDPOINT + SAMPLE_WIDTH'(product_q >>> ENV_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q  <= '0;
            sample_out <= MIDPOINT;
        end else begin
            product_q  <= product;
            sample_out <= rescaled;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven FSM stepping a level register on
// sample ticks, feeding a two-stage sample scaler.
module adsr_envelope
    import tracker_pkg::*;
#(
    parameter int                      ENV_WIDTH    = $bits(ENV_MAX),
    parameter int                      SAMPLE_WIDTH = 16,
    parameter logic [SAMPLE_WIDTH-1:0] MIDPOINT     = MIDPOINT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_active_high,
    input  logic                    sample_tick,
    input  logic                    gate,
    input  logic [ENV_WIDTH-1:0]    attack_step,
    input  logic [ENV_WIDTH-1:0]    decay_step,
    input  logic [ENV_WIDTH-1:0]    sustain_level,
    input  logic [ENV_WIDTH-1:0]    release_step,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic [ENV_WIDTH-1:0]    env_level,
    output logic [2:0]              env_state,
    output logic                    active
);

    localparam logic [ENV_WIDTH-1:0] LMAX = {ENV_WIDTH{1'b1}};

    env_state_t           state;
    logic [ENV_WIDTH-1:0] level;
    logic                 gate_d;
    logic                 armed;
    logic                 rise;
    logic                 fall;
    logic                 in_note;
    logic [ENV_WIDTH:0]   att_sum;
    logic [ENV_WIDTH:0]   dec_diff;
    logic [ENV_WIDTH:0]   rel_diff;

    assign att_sum  = {1'b0, level} + {1'b0, attack_step};
    assign dec_diff = {1'b0, level} - {1'b0, decay_step};
    assign rel_diff = {1'b0, level} - {1'b0, release_step};
    assign in_note  = state inside {S_ATTACK, S_DECAY, S_SUSTAIN};

    assign env_level = level;
    assign env_state = state;

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state  <= S_IDLE;
            level  <= '0;
            gate_d <= 1'b0;
            armed  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            active <= 1'b0;
        end else begin
            gate_d <= gate;
            // A gate held high across reset must drop before it can retrigger
            armed  <= armed | ~gate;
            rise   <= gate & ~gate_d & armed;
            fall   <= ~gate & gate_d;
            if (rise) begin
                state  <= S_ATTACK;
                active <= 1'b1;
            end else if (fall && in_note) begin
                state <= S_RELEASE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (sample_tick) level <= '0;
                    end
                    S_ATTACK: begin
                        if (sample_tick && attack_step != '0) begin
                            if (att_sum >= {1'b0, LMAX}) begin
                                level <= LMAX;
                                state <= S_DECAY;
                            end else begin
                                level <= att_sum[ENV_WIDTH-1:0];
                            end
                        end
                    end
                    S_DECAY: begin
                        if (sample_tick) begin
                            if (level < sustain_level) begin
                                level <= sustain_level;
                                state <= S_SUSTAIN;
                            end else if (decay_step != '0) begin
                                if (dec_diff[ENV_WIDTH] ||
                                    dec_diff[ENV_WIDTH-1:0] <= sustain_level) begin
                                    level <= sustain_level;
                                    state <= S_SUSTAIN;
                                end else begin
                                    level <= dec_diff[ENV_WIDTH-1:0];
                                end
                            end
                        end
                    end
                    S_SUSTAIN: begin
                        if (sample_tick) level <= sustain_level;
                    end
                    S_RELEASE: begin
                        if (sample_tick && release_step != '0) begin
                            if (rel_diff[ENV_WIDTH] ||
                                rel_diff[ENV_WIDTH-1:0] == '0) begin
                                level  <= '0;
                                state  <= S_IDLE;
                                active <= 1'b0;
                            end else begin
                                level <= rel_diff[ENV_WIDTH-1:0];
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

    envelope_scaler #(
        .ENV_WIDTH    (ENV_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .MIDPOINT     (MIDPOINT)
    ) u_scaler (
        .clk        (clk),
        .rst        (rst_active_high),
        .sample_in  (sample_in),
        .env_level  (level),
        .sample_out (sample_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: stimulus queues expectations tagged
// with the clock count they are due at; a negedge monitor compares them.
module tb_adsr_envelope;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    localparam int K_LEVEL  = 0;
    localparam int K_STATE  = 1;
    localparam int K_SAMPLE = 2;
    localparam int K_ACTIVE = 3;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    adsr_envelope dut (
        .clk             (clk),
        .rst_active_high (rst),
        .sample_tick     (sample_tick),
        .gate            (gate),
        .attack_step     (attack_step),
        .decay_step      (decay_step),
        .sustain_level   (sustain_level),
        .release_step    (release_step),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .env_level       (env_level),
        .env_state       (env_state),
        .active          (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t        keep[$];
        logic [15:0] act;
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_LEVEL:  act = env_level;
                    K_STATE:  act = {13'd0, env_state};
                    K_SAMPLE: act = sample_out;
                    default:  act = {15'd0, active};
                endcase
                n_checks++;
                if (act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h",
                             sb[i].name, act, sb[i].val);
                end
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: check missed at cycle %0d",
                         sb[i].name, sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic cyc_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(input int dly, input int kind,
                            input logic [15:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick_expect(input logic [15:0] lvl, input string name);
        push_exp(1, K_LEVEL, lvl, name);
        sample_tick = 1'b1;
        cyc_step(1);
        sample_tick = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        gate          = 1'b0;
        sample_tick   = 1'b0;
        attack_step   = 16'h0000;
        decay_step    = 16'h0000;
        sustain_level = 16'h0000;
        release_step  = 16'h0000;
        sample_in     = 16'h4000;
        cyc_step(1);
        push_exp(0, K_LEVEL, 16'h0000, "rst_level");
        push_exp(0, K_STATE, 16'h0000, "rst_state");
        push_exp(0, K_ACTIVE, 16'h0000, "rst_active");
        push_exp(0, K_SAMPLE, 16'h4000, "rst_sample");
        cyc_step(1);
        rst = 1'b0;
        cyc_step(2);

        // attack saturation
        attack_step   = 16'h4000;
        decay_step    = 16'h3000;
        sustain_level = 16'h8000;
        release_step  = 16'h2500;
        push_exp(1, K_STATE, 16'h0000, "gate_lat1");
        push_exp(2, K_STATE, 16'h0001, "gate_attack");
        push_exp(2, K_ACTIVE, 16'h0001, "active_on");
        gate = 1'b1;
        cyc_step(2);
        tick_expect(16'h4000, "att1");
        tick_expect(16'h8000, "att2");
        tick_expect(16'hC000, "att3");
        push_exp(1, K_STATE, 16'h0002, "att_to_decay");
        tick_expect(16'hFFFF, "att_sat");

        // decay into sustain
        tick_expect(16'hCFFF, "dec1");
        tick_expect(16'h9FFF, "dec2");
        push_exp(1, K_STATE, 16'h0003, "dec_to_sus");
        tick_expect(16'h8000, "dec_clamp");

        // scaling with level 0x8000 held
        push_exp(1, K_SAMPLE, 16'h4000, "scale_latency");
        sample_in = 16'h7FFF;
        push_exp(2, K_SAMPLE, 16'h5FFF, "scale_max");
        cyc_step(1);
        sample_in = 16'h0000;
        push_exp(2, K_SAMPLE, 16'h2000, "scale_min");
        cyc_step(1);
        sample_in = 16'h4000;
        push_exp(2, K_SAMPLE, 16'h4000, "scale_mid");
        cyc_step(2);

        // live sustain tracking
        sustain_level = 16'h6000;
        tick_expect(16'h6000, "sus_track");

        // release to idle, with a zero-step hold first
        push_exp(2, K_STATE, 16'h0004, "gate_release");
        gate = 1'b0;
        cyc_step(2);
        release_step = 16'h0000;
        push_exp(1, K_STATE, 16'h0004, "rel_zero_state");
        tick_expect(16'h6000, "rel_zero_step");
        release_step = 16'h2500;
        tick_expect(16'h3B00, "rel1");
        tick_expect(16'h1600, "rel2");
        push_exp(1, K_STATE, 16'h0000, "rel_idle");
        push_exp(1, K_ACTIVE, 16'h0000, "rel_inactive");
        tick_expect(16'h0000, "rel_floor");

        // retrigger during release, rise coincident with a tick
        attack_step = 16'h3000;
        push_exp(2, K_STATE, 16'h0001, "rt_attack");
        gate = 1'b1;
        cyc_step(2);
        tick_expect(16'h3000, "rt_att");
        push_exp(2, K_STATE, 16'h0004, "rt_release");
        gate = 1'b0;
        cyc_step(2);
        attack_step = 16'h4000;
        gate = 1'b1;
        cyc_step(1);
        push_exp(1, K_STATE, 16'h0001, "rt_state");
        push_exp(1, K_LEVEL, 16'h3000, "rt_hold");
        sample_tick = 1'b1;
        cyc_step(1);
        sample_tick = 1'b0;
        tick_expect(16'h7000, "rt_next");

        // single-tick saturation and decay underflow clamp
        attack_step = 16'hFFFF;
        push_exp(1, K_STATE, 16'h0002, "att_full_state");
        tick_expect(16'hFFFF, "att_full");
        decay_step = 16'hFFFF;
        push_exp(1, K_STATE, 16'h0003, "dec_uf_state");
        tick_expect(16'h6000, "dec_underflow");

        // async reset mid-sustain, gate held high throughout
        sample_in = 16'h7FFF;
        push_exp(2, K_SAMPLE, 16'h57FF, "scale_sus");
        cyc_step(3);
        rst = 1'b1;
        push_exp(0, K_LEVEL, 16'h0000, "async_level");
        push_exp(0, K_SAMPLE, 16'h4000, "async_sample");
        push_exp(0, K_STATE, 16'h0000, "async_state");
        push_exp(0, K_ACTIVE, 16'h0000, "async_active");
        cyc_step(2);
        rst = 1'b0;
        cyc_step(4);
        push_exp(0, K_STATE, 16'h0000, "no_retrigger");
        push_exp(0, K_ACTIVE, 16'h0000, "no_retrig_active");
        push_exp(0, K_SAMPLE, 16'h4000, "idle_sample");
        cyc_step(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude-envelope stage sitting directly downstream of the DDS sine voice. It consumes the voice's 16-bit offset-binary sample, runs an attack/decay/sustain/release state machine driven by a note gate and an envelope-rate tick, and scales the sample about its midpoint by the current envelope level. Its output feeds the channel mixer.

## Interface
Parameters:
- ENV_WIDTH, 16, envelope level and step width; ENV_MAX = all ones
- SAMPLE_WIDTH, 16, sample width in and out
- MIDPOINT, 16'h4000, offset-binary zero level of the voice sample (voice range 0x0000..0x7FFF)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_active_high  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle strobe; envelope advances only on this strobe
- gate  in  1  note on (1) / note off (0), level signal
- attack_step  in  ENV_WIDTH  increment per tick in ATTACK
- decay_step  in  ENV_WIDTH  decrement per tick in DECAY
- sustain_level  in  ENV_WIDTH  SUSTAIN target level
- release_step  in  ENV_WIDTH  decrement per tick in RELEASE
- sample_in  in  SAMPLE_WIDTH  voice sample, offset binary
- sample_out  out  SAMPLE_WIDTH  scaled sample, offset binary about MIDPOINT
- env_level  out  ENV_WIDTH  current envelope level (registered)
- env_state  out  3  current state encoding
- active  out  1  high when state != IDLE

## Operation
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Encodings 5..7 are illegal and recover to IDLE with level held.
- Gate edges: gate registered into gate_d every clk.
  - Rise (gate & ~gate_d): any state -> ATTACK. Level is not cleared (retrigger continues from the current level).
  - Fall: ATTACK/DECAY/SUSTAIN -> RELEASE.
- An edge in the same cycle as sample_tick: the state change wins, and there is no level update that cycle.
- Level updates occur on sample_tick only. Sums are computed at ENV_WIDTH+1 bits and then saturated.
  - ATTACK: level = min(level+attack_step, ENV_MAX). On reaching ENV_MAX -> DECAY.
  - DECAY: level = max(level-decay_step, sustain_level). On reaching sustain_level -> SUSTAIN. If level < sustain_level on entry, level = sustain_level -> SUSTAIN.
  - SUSTAIN: level = sustain_level every tick, so live changes are tracked.
  - RELEASE: level = max(level-release_step, 0). On reaching 0 -> IDLE.
  - IDLE: level held at 0.
- A step of 0 holds the level, and the state does not advance.
- Scaling (sub-module):
  - c = signed(sample_in) - MIDPOINT, 17-bit signed.
  - p = c * {1'b0, env_level}, 34-bit signed.
  - sample_out = MIDPOINT + (p >>> ENV_WIDTH), truncated to SAMPLE_WIDTH.
  - Result always lies within 0x0000..0x7FFF for a legal input.

## Timing
- Reset (asynchronous assert; release synchronous to clk): state IDLE, env_level 0, gate_d 0, active 0, sample_out MIDPOINT, pipeline registers cleared to the midpoint/zero equivalent.
- Gate edge to env_state change: 2 clk after gate changes (1 for gate_d, 1 for state register).
- sample_tick to env_level update: 1 clk.
- sample_in to sample_out: 2 clk.
  - Stage 1 registers p, using env_level as presented in that cycle.
  - Stage 2 registers the shift and add.
- No stall or backpressure. The pipeline runs every clk.
- Reset asserted mid-note: outputs return to reset values immediately. After release, the block waits for a fresh gate rise; a gate held high through reset does not retrigger.

## Structure
- tracker_pkg holds:
  - env_state_t enum (3-bit, values above)
  - ENV_MAX constant
  - MIDPOINT default
- The scaling datapath is the sub-module envelope_scaler: two-stage multiply, shift and re-offset, parameterised by ENV_WIDTH/SAMPLE_WIDTH/MIDPOINT.
- The FSM and level register live in adsr_envelope.

## Test plan
- Attack saturation: attack_step 0x4000, gate rise, ticks -> env_level 0x4000, 0x8000, 0xC000, 0xFFFF; state DECAY after the 4th tick.
- Decay/sustain: decay_step 0x3000, sustain 0x8000 from 0xFFFF -> 0xCFFF, 0x9FFF, 0x8000 (clamped); state SUSTAIN. Changing sustain_level to 0x6000 -> level 0x6000 on the next tick.
- Release to idle: gate fall at 0x6000, release_step 0x2500 -> 0x3B00, 0x1600, 0x0000; state IDLE, active 0.
- Scaling: env_level 0x8000 held; sample_in 0x7FFF -> sample_out 0x5FFF; 0x0000 -> 0x2000; 0x4000 -> 0x4000; each 2 clk later.
- Retrigger plus collision: gate fall then rise during RELEASE at 0x3000, with the rise edge coincident with a tick -> ATTACK, level stays 0x3000 that cycle, next tick 0x7000.
- Async reset mid-SUSTAIN: env_level 0, sample_out 0x4000 before the next clk edge. With gate held high after release, state remains IDLE.
